// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I memory stage.
//   - func3 encodings for loads (LB..LHU) and stores (SB..SW)
//   - memory-stage FSM state enum
//   - helpers for legality, alignment, store byte enables and store data
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    // Load func3 011/110/111 and store func3 >= 011 have no meaning in RV32I.
    function automatic logic func3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 > F3_SW);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size is carried in func3[1:0] for both loads and stores.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_SB:   return 4'b0001 << lo;
            F3_SH:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store datum into every lane so the byte enables pick it out.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            F3_SB:   return {4{data[7:0]}};
            F3_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed lane of the read word and
// sign- or zero-extends it according to func3.
//   func3 : load width/signedness
//   lane  : byte offset within the word (addr[1:0])
//   rdata : raw word from data memory
//   data  : extended load result
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Halfword loads are aligned, so only lane[1] matters.
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (func3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// RV32I memory stage: issues data-memory requests for loads/stores, stalls
// the upstream pipeline while a request is outstanding, flags misaligned or
// illegal accesses, and drives the MEM/WB pipeline register.
//
// Handshake: dmemReq rises on entry to ACCESS and stays high, with
// dmemWe/dmemAddr/dmemByteEn/dmemWdata frozen, until the cycle in which
// dmemReady=1; that cycle completes the transfer (dmemRdata valid) and the
// FSM returns to IDLE at the following edge.
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   *_EX_MEM                  EX/MEM register contents (held while stallMem=1)
//   dmemReq/We/Addr/ByteEn/Wdata, dmemRdata, dmemReady   data-memory port
//   stallMem                  freeze IF..EX and hold EX/MEM
//   misalign                  one-cycle pulse for a misaligned/illegal access
//   *_MEM_WB                  MEM/WB register outputs
//   fsm_state                 current FSM state (debug)
module mem_stage_access
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic        valid_EX_MEM,
    input  logic        memWrite_EX_MEM,
    input  logic        memRead_EX_MEM,
    input  logic        regWrite_EX_MEM,
    input  logic        memToRegWrite_EX_MEM,
    input  logic [2:0]  func3_EX_MEM,
    input  logic [31:0] aluOut_EX_MEM,
    input  logic [31:0] storeData_EX_MEM,
    input  logic [4:0]  rd_EX_MEM,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemByteEn,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemReady,
    output logic        stallMem,
    output logic        misalign,
    output logic        regWrite_MEM_WB,
    output logic        memToRegWrite_MEM_WB,
    output logic [4:0]  rd_MEM_WB,
    output logic [31:0] aluOut_MEM_WB,
    output logic [31:0] loadData_MEM_WB,
    output mem_state_e  fsm_state
);

    mem_state_e  state, state_next;
    logic        mem_op, fault, start, stall_c;

    // Request captured on entry to ACCESS; drives the dmem port and MEM/WB.
    logic [31:0] req_alu;
    logic [2:0]  req_f3;
    logic [4:0]  req_rd;
    logic        req_regwrite, req_memtoreg;
    logic [31:0] load_word;

    always_comb begin
        mem_op = valid_EX_MEM & (memRead_EX_MEM | memWrite_EX_MEM);
        fault  = mem_op & (func3_illegal(memWrite_EX_MEM, func3_EX_MEM) |
                           addr_misaligned(func3_EX_MEM, aluOut_EX_MEM[1:0]));
        start  = mem_op & ~fault;

        state_next = state;
        stall_c    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (start) begin
                    stall_c    = 1'b1;
                    state_next = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                if (dmemReady) state_next = MEM_IDLE;
                else           stall_c    = 1'b1;
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    // stallMem is combinational from the inputs; gate it so reset forces it low.
    assign stallMem  = stall_c & rstN;
    assign dmemReq   = (state == MEM_ACCESS);
    assign dmemAddr  = {req_alu[31:2], 2'b00};
    assign fsm_state = state;

    load_align u_load_align (
        .func3 (req_f3),
        .lane  (req_alu[1:0]),
        .rdata (dmemRdata),
        .data  (load_word)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state                <= MEM_IDLE;
            misalign             <= 1'b0;
            dmemWe               <= 1'b0;
            dmemByteEn           <= 4'h0;
            dmemWdata            <= 32'h0;
            req_alu              <= 32'h0;
            req_f3               <= 3'h0;
            req_rd               <= 5'h0;
            req_regwrite         <= 1'b0;
            req_memtoreg         <= 1'b0;
            regWrite_MEM_WB      <= 1'b0;
            memToRegWrite_MEM_WB <= 1'b0;
            rd_MEM_WB            <= 5'h0;
            aluOut_MEM_WB        <= 32'h0;
            loadData_MEM_WB      <= 32'h0;
        end else begin
            state    <= state_next;
            misalign <= 1'b0;
            // Default: MEM/WB receives a bubble (no register write).
            regWrite_MEM_WB      <= 1'b0;
            memToRegWrite_MEM_WB <= 1'b0;
            rd_MEM_WB            <= 5'h0;
            aluOut_MEM_WB        <= 32'h0;
            loadData_MEM_WB      <= 32'h0;
            case (state)
                MEM_IDLE: begin
                    if (start) begin
                        dmemWe       <= memWrite_EX_MEM;
                        dmemByteEn   <= memWrite_EX_MEM ?
                                        store_byte_en(func3_EX_MEM, aluOut_EX_MEM[1:0]) : 4'b1111;
                        dmemWdata    <= store_wdata(func3_EX_MEM, storeData_EX_MEM);
                        req_alu      <= aluOut_EX_MEM;
                        req_f3       <= func3_EX_MEM;
                        req_rd       <= rd_EX_MEM;
                        req_regwrite <= regWrite_EX_MEM;
                        req_memtoreg <= memToRegWrite_EX_MEM;
                    end else begin
                        // Non-memory op, empty slot, or faulting access:
                        // passes straight through; faults never write rd.
                        misalign             <= fault;
                        regWrite_MEM_WB      <= valid_EX_MEM & regWrite_EX_MEM & ~fault;
                        memToRegWrite_MEM_WB <= memToRegWrite_EX_MEM;
                        rd_MEM_WB            <= rd_EX_MEM;
                        aluOut_MEM_WB        <= aluOut_EX_MEM;
                    end
                end
                MEM_ACCESS: begin
                    if (dmemReady) begin
                        regWrite_MEM_WB      <= req_regwrite;
                        memToRegWrite_MEM_WB <= req_memtoreg;
                        rd_MEM_WB            <= req_rd;
                        aluOut_MEM_WB        <= req_alu;
                        loadData_MEM_WB      <= load_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        valid_EX_MEM, memWrite_EX_MEM, memRead_EX_MEM;
    logic        regWrite_EX_MEM, memToRegWrite_EX_MEM;
    logic [2:0]  func3_EX_MEM;
    logic [31:0] aluOut_EX_MEM, storeData_EX_MEM;
    logic [4:0]  rd_EX_MEM;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemByteEn;
    logic        dmemReady, stallMem, misalign;
    logic        regWrite_MEM_WB, memToRegWrite_MEM_WB;
    logic [4:0]  rd_MEM_WB;
    logic [31:0] aluOut_MEM_WB, loadData_MEM_WB;
    mem_state_e  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];   // {rd, writeback value}

    mem_stage_access dut (
        .clk(clk), .rstN(rstN),
        .valid_EX_MEM(valid_EX_MEM), .memWrite_EX_MEM(memWrite_EX_MEM),
        .memRead_EX_MEM(memRead_EX_MEM), .regWrite_EX_MEM(regWrite_EX_MEM),
        .memToRegWrite_EX_MEM(memToRegWrite_EX_MEM), .func3_EX_MEM(func3_EX_MEM),
        .aluOut_EX_MEM(aluOut_EX_MEM), .storeData_EX_MEM(storeData_EX_MEM),
        .rd_EX_MEM(rd_EX_MEM),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemByteEn(dmemByteEn), .dmemWdata(dmemWdata), .dmemRdata(dmemRdata),
        .dmemReady(dmemReady), .stallMem(stallMem), .misalign(misalign),
        .regWrite_MEM_WB(regWrite_MEM_WB), .memToRegWrite_MEM_WB(memToRegWrite_MEM_WB),
        .rd_MEM_WB(rd_MEM_WB), .aluOut_MEM_WB(aluOut_MEM_WB),
        .loadData_MEM_WB(loadData_MEM_WB), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {addr[1:0], 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        int size;
        logic [3:0] be;
        if (!st) return 4'b1111;
        size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        be = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= int'(lo) && i < int'(lo) + size) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3 == 3'b001) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // ---------------- scoreboard: writeback monitor ----------------
    always @(negedge clk) begin
        if (rstN === 1'b1 && regWrite_MEM_WB === 1'b1) begin
            logic [36:0] got, exp;
            got = {rd_MEM_WB, (memToRegWrite_MEM_WB ? loadData_MEM_WB : aluOut_MEM_WB)};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d val=%h, required no writeback", got[36:32], got[31:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL wb_data: got rd=%0d val=%h, required rd=%0d val=%h",
                             got[36:32], got[31:0], exp[36:32], exp[31:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        valid_EX_MEM = 0; memWrite_EX_MEM = 0; memRead_EX_MEM = 0;
        regWrite_EX_MEM = 0; memToRegWrite_EX_MEM = 0; func3_EX_MEM = 0;
        aluOut_EX_MEM = 0; storeData_EX_MEM = 0; rd_EX_MEM = 0;
        dmemReady = 0; dmemRdata = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            clear_inputs();
        end
    endtask

    task automatic do_alu(input logic [31:0] result, input logic [4:0] rd);
        @(posedge clk); #1;
        clear_inputs();
        valid_EX_MEM = 1; regWrite_EX_MEM = 1; aluOut_EX_MEM = result; rd_EX_MEM = rd;
        exp_q.push_back({rd, result});
        @(negedge clk);
        n_checks++;
        if (stallMem !== 1'b0 || dmemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_nostall: stall=%b req=%b, required 0 0", stallMem, dmemReq);
        end
    endtask

    task automatic do_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input logic [4:0] rd, input int waits);
        int stalls;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_addr;
        exp_be   = model_be(st, f3, addr[1:0]);
        exp_wd   = model_wd(f3, sdata);
        exp_addr = {addr[31:2], 2'b00};
        @(posedge clk); #1;
        clear_inputs();
        valid_EX_MEM = 1; memWrite_EX_MEM = st; memRead_EX_MEM = ~st;
        regWrite_EX_MEM = ~st; memToRegWrite_EX_MEM = ~st;
        func3_EX_MEM = f3; aluOut_EX_MEM = addr; storeData_EX_MEM = sdata; rd_EX_MEM = rd;
        if (!st) exp_q.push_back({rd, model_load(f3, addr, rdata)});
        stalls = 0;
        @(negedge clk);
        n_checks++;
        if (stallMem !== 1'b1 || dmemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_first: stall=%b req=%b, required 1 0", stallMem, dmemReq);
        end
        if (stallMem === 1'b1) stalls++;
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            dmemReady = (k == waits);
            dmemRdata = (k == waits) ? rdata : $urandom();
            @(negedge clk);
            n_checks++;
            if (st) begin
                if ({dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata} !== {2'b11, exp_addr, exp_be, exp_wd}) begin
                    n_fail++;
                    $display("FAIL mem_port_st: req=%b we=%b addr=%h be=%b wd=%h, required 1 1 %h %b %h",
                             dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata, exp_addr, exp_be, exp_wd);
                end
            end else begin
                if ({dmemReq, dmemWe, dmemAddr, dmemByteEn} !== {2'b10, exp_addr, exp_be}) begin
                    n_fail++;
                    $display("FAIL mem_port_ld: req=%b we=%b addr=%h be=%b, required 1 0 %h %b",
                             dmemReq, dmemWe, dmemAddr, dmemByteEn, exp_addr, exp_be);
                end
            end
            if (stallMem === 1'b1) stalls++;
        end
        n_checks++;
        if (stalls != waits + 1) begin
            n_fail++;
            $display("FAIL stall_len: got %0d stall cycles, required %0d", stalls, waits + 1);
        end
    endtask

    task automatic do_bad(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        clear_inputs();
        valid_EX_MEM = 1; memWrite_EX_MEM = st; memRead_EX_MEM = ~st;
        regWrite_EX_MEM = ~st; memToRegWrite_EX_MEM = ~st;
        func3_EX_MEM = f3; aluOut_EX_MEM = addr; rd_EX_MEM = 5'd9;
        @(negedge clk);
        n_checks++;
        if (stallMem !== 1'b0 || dmemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_nostall: stall=%b req=%b, required 0 0", stallMem, dmemReq);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (misalign !== 1'b1 || regWrite_MEM_WB !== 1'b0 || dmemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_pulse: misalign=%b wb=%b req=%b, required 1 0 0", misalign, regWrite_MEM_WB, dmemReq);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_one_cycle: misalign=%b, required 0", misalign);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstN = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        // A legal memory op presented during reset must not raise stall.
        valid_EX_MEM = 1; memRead_EX_MEM = 1; func3_EX_MEM = F3_LW; aluOut_EX_MEM = 32'h40;
        @(negedge clk);
        n_checks++;
        if ({dmemReq, stallMem, misalign, regWrite_MEM_WB, memToRegWrite_MEM_WB} !== 5'b0 ||
            rd_MEM_WB !== 5'd0 || aluOut_MEM_WB !== 32'd0 || loadData_MEM_WB !== 32'd0 ||
            fsm_state !== MEM_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: req=%b stall=%b mis=%b wb=%b m2r=%b rd=%0d alu=%h ld=%h st=%0d, required all 0",
                     dmemReq, stallMem, misalign, regWrite_MEM_WB, memToRegWrite_MEM_WB,
                     rd_MEM_WB, aluOut_MEM_WB, loadData_MEM_WB, fsm_state);
        end
        clear_inputs();
        @(negedge clk);
        rstN = 1;
    endtask

    task automatic test_lw_fast();
        do_mem(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 5'd1, 0);
        idle_cycles(1);
    endtask

    task automatic test_sb_wait();
        do_mem(1'b1, F3_SB, 32'h203, 32'h000000A5, 32'h0, 5'd0, 3);
        idle_cycles(1);
        do_mem(1'b1, F3_SH, 32'h406, 32'h1234BEEF, 32'h0, 5'd0, 1);
        idle_cycles(1);
    endtask

    task automatic test_lb_lbu();
        do_mem(1'b0, F3_LB, 32'h101, 32'h0, 32'h00008000, 5'd2, 1);
        do_mem(1'b0, F3_LBU, 32'h101, 32'h0, 32'h00008000, 5'd3, 0);
        do_mem(1'b0, F3_LH, 32'h102, 32'h0, 32'h9ABC0000, 5'd4, 2);
        do_mem(1'b0, F3_LHU, 32'h102, 32'h0, 32'h9ABC0000, 5'd5, 0);
        idle_cycles(1);
    endtask

    task automatic test_misalign();
        do_bad(1'b0, F3_LW, 32'h102);
        do_bad(1'b0, F3_LH, 32'h101);
        do_bad(1'b1, F3_SW, 32'h201);
        do_bad(1'b0, 3'b011, 32'h100);
        do_bad(1'b1, 3'b100, 32'h100);
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        clear_inputs();
        valid_EX_MEM = 1; memRead_EX_MEM = 1; regWrite_EX_MEM = 1; memToRegWrite_EX_MEM = 1;
        func3_EX_MEM = F3_LW; aluOut_EX_MEM = 32'h300; rd_EX_MEM = 5'd7;
        repeat (2) @(posedge clk);   // now in the second ACCESS cycle
        #3;
        rstN = 0;
        #1;
        n_checks++;
        if (dmemReq !== 1'b0 || stallMem !== 1'b0 || fsm_state !== MEM_IDLE || regWrite_MEM_WB !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: req=%b stall=%b st=%0d wb=%b, required 0 0 0 0",
                     dmemReq, stallMem, fsm_state, regWrite_MEM_WB);
        end
        clear_inputs();
        @(negedge clk);
        rstN = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (dmemReq !== 1'b0 || stallMem !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_reissue: req=%b stall=%b, required 0 0", dmemReq, stallMem);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_alu(32'h55, 5'd10);
        do_mem(1'b0, F3_LH, 32'h0000_0412, 32'h0, 32'h8001_7FFF, 5'd11, 1);
        do_alu(32'h66, 5'd12);
        do_alu(32'h77, 5'd13);
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic [2:0]  ld_f3[5];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        st;
        ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        for (int i = 0; i < 12; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            addr = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
            if (f3[1:0] == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01) addr[1] = 1'($urandom_range(0, 1));
            do_mem(st, f3, addr, $urandom(), $urandom(), 5'($urandom_range(1, 31)),
                   $urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) do_alu($urandom(), 5'($urandom_range(1, 31)));
        end
        idle_cycles(2);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_lw_fast();
        test_sb_wait();
        test_lb_lbu();
        test_misalign();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        idle_cycles(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wb_missing: %0d writebacks outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
